// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_ctrl
// Purpose  : EX-stage iterative MULT/MULTU/DIV/DIVU sequencer with stall request
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    input  logic             hold,
    output logic             stallreq,
    output logic             busy,
    output logic             hilo_we,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi_res;
    logic [WIDTH-1:0] r_lo_res;

    logic             w_sa;
    logic             w_sb;
    logic             w_dz;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_fin_hi;
    logic [WIDTH-1:0] w_fin_lo;

    // Operand capture: signed ops work on magnitudes, sign fixed up at the end.
    always_comb begin
        w_sa    = ~op[0] & src_a[WIDTH-1];
        w_sb    = ~op[0] & src_b[WIDTH-1];
        w_dz    = op[1] & (src_b == '0);
        w_abs_a = w_sa ? (~src_a + 1'b1) : src_a;
        w_abs_b = w_sb ? (~src_b + 1'b1) : src_b;
    end

    // One iteration: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_shift  = {r_hi, r_lo[WIDTH-1]};
        w_diff   = w_shift - {1'b0, r_b};
        w_ge     = (w_shift >= {1'b0, r_b});
        w_hi_nxt = '0;
        w_lo_nxt = '0;
        if (r_div) begin
            w_hi_nxt = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], w_ge};
        end else begin
            w_hi_nxt = w_sum[WIDTH:1];
            w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
        end
        w_prod = {w_hi_nxt, w_lo_nxt};
        if (r_neg_q) begin
            w_prod = ~w_prod + 1'b1;
        end
        if (r_div) begin
            w_fin_hi = r_neg_r ? (~w_hi_nxt + 1'b1) : w_hi_nxt;
            w_fin_lo = r_neg_q ? (~w_lo_nxt + 1'b1) : w_lo_nxt;
        end else begin
            w_fin_hi = w_prod[2*WIDTH-1:WIDTH];
            w_fin_lo = w_prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_div    <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_hi_res <= '0;
            r_lo_res <= '0;
        end else if (cancel) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // Divide-by-zero runs unsigned on the raw dividend so the
                        // remainder comes out as the dividend and the quotient all ones.
                        r_div   <= op[1];
                        r_neg_q <= ~w_dz & (w_sa ^ w_sb);
                        r_neg_r <= ~w_dz & w_sa;
                        r_hi    <= '0;
                        r_lo    <= w_dz ? src_a : w_abs_a;
                        r_b     <= w_abs_b;
                        r_cnt   <= '0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_hi  <= w_hi_nxt;
                    r_lo  <= w_lo_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == c_LAST) begin
                        r_hi_res <= w_fin_hi;
                        r_lo_res <= w_fin_lo;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!hold) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stallreq = (r_state == S_BUSY) || ((r_state == S_IDLE) && start && !cancel);
    assign busy     = (r_state != S_IDLE);
    assign hilo_we  = (r_state == S_DONE) && !hold && !cancel;
    assign hi_out   = r_hi_res;
    assign lo_out   = r_lo_res;

endmodule
`default_nettype wire

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Multi-cycle multiply/divide sequencer in the EX stage of the 5-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU from the EX-stage decode and runs an iterative shift-add multiplier or restoring divider over WIDTH cycles. While it runs it raises a stall request to the pipeline control. When the result is accepted it issues a single-cycle HI/LO write.

Parameters:
WIDTH, 32, operand width; sets the iteration count and the HI/LO width.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  EX-stage instruction is mult/multu/div/divu; level, may stay high while EX is stalled
op  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu; sampled with start in IDLE
src_a  in  WIDTH  rs value (forwarded); sampled with start in IDLE
src_b  in  WIDTH  rt value (forwarded); sampled with start in IDLE
cancel  in  1  pipeline flush of the EX instruction; aborts the operation
hold  in  1  downstream stall; holds the block in DONE
stallreq  out  1  stall request to pipeline control (combinational)
busy  out  1  state != IDLE
hilo_we  out  1  one-cycle HI/LO write strobe
hi_out  out  WIDTH  HI result (product[2W-1:W] / remainder)
lo_out  out  WIDTH  LO result (product[W-1:0] / quotient)

Behaviour:
- States: IDLE, BUSY, DONE. Iteration counter is clog2(WIDTH) bits.
- Reset: state=IDLE, counter=0, internal accumulators=0, hi_out=lo_out=0, hilo_we=0, busy=0, stallreq=0.
- IDLE with start=1 and cancel=0:
  - Latch op, operand magnitudes (absolute value for signed ops) and result signs.
  - Product sign = a[W-1]^b[W-1]. Quotient sign = a^b. Remainder sign = a's sign.
  - Go to BUSY with counter=0.
  - stallreq=1 combinationally in this same cycle.
- BUSY:
  - One iteration per cycle: mult adds and shifts one multiplier bit; div does one restoring shift-subtract, producing one quotient bit.
  - stallreq=1.
  - After the iteration with counter=WIDTH-1, apply sign correction (two's-complement negate where the sign is set), load hi_out/lo_out, and go to DONE.
  - Total: start cycle plus WIDTH BUSY cycles, so DONE is reached at cycle WIDTH+1.
- DONE:
  - stallreq=0, so the instruction advances.
  - start is ignored, so the still-asserted start does not retrigger.
  - If hold=0: hilo_we=1 this cycle and next state is IDLE.
  - If hold=1: stay in DONE with hilo_we=0; results stay stable.
- cancel (any state): next state IDLE, counter cleared, hilo_we=0 in that cycle. hi_out/lo_out keep their last value. cancel has priority over start and over completion.
- Divide by zero: quotient = all ones, remainder = dividend, no sign correction. This holds for both signed and unsigned divides. The full WIDTH-cycle latency still applies.
- Signed overflow: -2^(W-1) / -1 gives LO=0x80000000, HI=0. The magnitude is computed in W-bit unsigned, so it must not truncate.
- hi_out/lo_out change only on the BUSY→DONE transition.
- After DONE→IDLE, a new start is accepted in the very next cycle.
- rst mid-operation: back to the reset values next cycle, with no HI/LO write.

Test Plan:
- mult 0xFFFFFFFF × 0x00000002 → stallreq high for 33 cycles, then hilo_we pulse; HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu same operands → HI=0x00000001, LO=0xFFFFFFFE; 0x80000000×0x80000000 signed → HI=0x40000000, LO=0.
- div -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- divu 7 / 0 → LO=0xFFFFFFFF, HI=0x00000007 after the full latency.
- Start, then cancel at BUSY cycle 10 → IDLE next cycle, no hilo_we, prior HI/LO unchanged; start next cycle runs normally.
- hold=1 for 3 cycles on reaching DONE, start kept high → stallreq=0, no retrigger, hilo_we only in the cycle hold drops; back-to-back second op begins the following cycle.
